core_timer_regbus_arb: RTL and testbench



---
 rtl/core_timer_arb_pkg.sv | 17 +
 rtl/core_timer_regbus_arb_if.sv | 56 +++++
 rtl/core_timer_rr_pick.sv | 28 ++
 rtl/core_timer_regbus_arb.sv | 137 +++++++++++++
 tb/tb_core_timer_regbus_arb.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_timer_arb_pkg.sv
// Shared types and constants for the core timer reg-bus arbiter.
// Used by core_timer_regbus_arb, its interface and the round-robin picker.
package core_timer_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } arb_state_e;

endpackage

// File: rtl/core_timer_regbus_arb_if.sv
// Requester and reg-bus signal bundle for core_timer_regbus_arb.
// lock_m1 exists only when CORE_TIMER_ARB_LOCK_EN is defined.
interface core_timer_regbus_arb_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);

  logic              req_m0;
  logic              req_m1;
  logic              wr1_rd0_m0;
  logic              wr1_rd0_m1;
  logic [ADDR_W-1:0] addr_m0;
  logic [ADDR_W-1:0] addr_m1;
  logic [DATA_W-1:0] wdata_m0;
  logic [DATA_W-1:0] wdata_m1;
  logic              gnt_m0;
  logic              gnt_m1;
  logic              rvalid_m0;
  logic              rvalid_m1;
  logic [DATA_W-1:0] rdata_m0;
  logic [DATA_W-1:0] rdata_m1;
`ifdef CORE_TIMER_ARB_LOCK_EN
  logic              lock_m1;
`endif

  logic              valid_reg_access;
  logic [ADDR_W-1:0] addr;
  logic              rd_wr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  // Arbiter view: serves the requesters and drives the register bus.
  modport master (
`ifdef CORE_TIMER_ARB_LOCK_EN
    input  lock_m1,
`endif
    input  req_m0, req_m1, wr1_rd0_m0, wr1_rd0_m1,
    input  addr_m0, addr_m1, wdata_m0, wdata_m1,
    input  read_data,
    output gnt_m0, gnt_m1, rvalid_m0, rvalid_m1, rdata_m0, rdata_m1,
    output valid_reg_access, addr, rd_wr, write_data
  );

  // Environment view: requesters plus the register block.
  modport slave (
`ifdef CORE_TIMER_ARB_LOCK_EN
    output lock_m1,
`endif
    output req_m0, req_m1, wr1_rd0_m0, wr1_rd0_m1,
    output addr_m0, addr_m1, wdata_m0, wdata_m1,
    output read_data,
    input  gnt_m0, gnt_m1, rvalid_m0, rvalid_m1, rdata_m0, rdata_m1,
    input  valid_reg_access, addr, rd_wr, write_data
  );

endinterface

// File: rtl/core_timer_rr_pick.sv
// Two-way round-robin selector; the pointer names the side that wins a tie.
module core_timer_rr_pick
  import core_timer_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       any,
  output logic       pick
);

  logic ptr_q;

  assign any  = |req;
  assign pick = (req[0] & req[1]) ? ptr_q : req[1];

  // After a grant the other side gets priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= M0;
    end else if (upd) begin
      ptr_q <= ~upd_id;
    end
  end

endmodule

// File: rtl/core_timer_regbus_arb.sv
// Round-robin arbiter serialising core and debug accesses onto the timer reg bus.
// Optional m1 lock (atomic lo/hi pairs) enabled by CORE_TIMER_ARB_LOCK_EN.
module core_timer_regbus_arb
  import core_timer_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic                    HCLK,
  input logic                    HRESET,
  core_timer_regbus_arb_if.master bus
);

  arb_state_e        state_q, state_d;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_wr_q;
  logic [DATA_W-1:0] rdata_m0_q, rdata_m1_q;
  logic              rvalid_m0_q, rvalid_m1_q;

  logic [1:0] req_vec;
  logic       any_req;
  logic       pick;
  logic       capture;
  logic       ptr_upd;
  logic       locked;
  logic       lock_cap;

  assign req_vec = {bus.req_m1, bus.req_m0 & ~locked};

  core_timer_rr_pick u_pick (
    .clk    (HCLK),
    .rst    (HRESET),
    .req    (req_vec),
    .upd    (ptr_upd),
    .upd_id (owner_q),
    .any    (any_req),
    .pick   (pick)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    ptr_upd = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StAccess;
          capture = 1'b1;
        end
      end
      StAccess: begin
        state_d = StResp;
        ptr_upd = ~(owner_q & lock_cap);
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= StIdle;
      owner_q     <= M0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_wr_q     <= 1'b0;
      rdata_m0_q  <= '0;
      rdata_m1_q  <= '0;
      rvalid_m0_q <= 1'b0;
      rvalid_m1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rvalid_m0_q <= 1'b0;
      rvalid_m1_q <= 1'b0;
      if (capture) begin
        owner_q <= pick;
        addr_q  <= pick ? bus.addr_m1 : bus.addr_m0;
        wdata_q <= pick ? bus.wdata_m1 : bus.wdata_m0;
        rd_wr_q <= pick ? bus.wr1_rd0_m1 : bus.wr1_rd0_m0;
      end
      // read_data is valid in RESP; writes complete with zero data.
      if (state_q == StResp) begin
        if (owner_q == M0) begin
          rvalid_m0_q <= 1'b1;
          rdata_m0_q  <= rd_wr_q ? '0 : bus.read_data;
        end else begin
          rvalid_m1_q <= 1'b1;
          rdata_m1_q  <= rd_wr_q ? '0 : bus.read_data;
        end
      end
    end
  end

`ifdef CORE_TIMER_ARB_LOCK_EN
  logic lock_cap_q;
  logic locked_q;

  // Lock is taken from m1's captured lock bit and released on its unlocked completion.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      lock_cap_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      if (capture) begin
        lock_cap_q <= pick & bus.lock_m1;
      end
      if (state_q == StResp) begin
        locked_q <= lock_cap_q;
      end
    end
  end

  assign locked   = locked_q;
  assign lock_cap = lock_cap_q;
`else
  assign locked   = 1'b0;
  assign lock_cap = 1'b0;
`endif

  assign bus.gnt_m0           = (state_q == StAccess) && (owner_q == M0);
  assign bus.gnt_m1           = (state_q == StAccess) && (owner_q == M1);
  assign bus.valid_reg_access = (state_q == StAccess);
  assign bus.addr             = addr_q;
  assign bus.rd_wr            = rd_wr_q;
  assign bus.write_data       = wdata_q;
  assign bus.rvalid_m0        = rvalid_m0_q;
  assign bus.rvalid_m1        = rvalid_m1_q;
  assign bus.rdata_m0         = rdata_m0_q;
  assign bus.rdata_m1         = rdata_m1_q;

endmodule

// File: tb/tb_core_timer_regbus_arb.sv
// Self-checking bench for core_timer_regbus_arb: transaction-level model plus directed checks.
module tb_core_timer_regbus_arb;
  import core_timer_arb_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  core_timer_regbus_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  core_timer_regbus_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: one access occupies IDLE-decision, ACCESS, RESP; completion visible 3 cycles on.
  bit          m_started = 0;
  int          m_acc = -100, m_done = -100, m_next = 0;
  int          m_own = 0, m_ptr = 0, mc;
  bit          m_lock_on = 0, mr0, mr1, lk;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_wr;
  logic [31:0] m_rd [2];

  // Observation logs.
  int          gl_id[$], gl_cyc[$];
  int          rv_cnt0 = 0, rv_cnt1 = 0, n_strobe = 0;
  logic [15:0] st_addr;
  logic [31:0] st_wd;
  logic        st_wr;
  bit          pend0 = 0, pend1 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge HCLK) begin
    mc = cyc;
    if (HRESET) begin
      m_started = 1;
      m_acc = -100;
      m_done = -100;
      m_next = mc + 1;
      m_rd[0] = '0;
      m_rd[1] = '0;
      m_ptr = 0;
      m_lock_on = 0;
    end else begin
      if (mc == m_acc + 1) m_rd[m_own] = m_wr ? 32'h0 : bus.read_data;
      if (m_started && mc >= m_next) begin
        mr0 = bus.req_m0 && !m_lock_on;
        mr1 = bus.req_m1;
        if (mr0 || mr1) begin
          m_own = (mr0 && mr1) ? m_ptr : (mr1 ? 1 : 0);
          lk = 0;
`ifdef CORE_TIMER_ARB_LOCK_EN
          lk = (m_own == 1) && bus.lock_m1;
`endif
          m_addr  = (m_own == 1) ? bus.addr_m1 : bus.addr_m0;
          m_wdata = (m_own == 1) ? bus.wdata_m1 : bus.wdata_m0;
          m_wr    = (m_own == 1) ? bus.wr1_rd0_m1 : bus.wr1_rd0_m0;
          m_acc  = mc + 1;
          m_done = mc + 3;
          m_next = mc + 3;
          if (!lk) m_ptr = 1 - m_own;
          m_lock_on = lk;
        end
      end
    end
    cyc++;
  end

  always @(negedge HCLK) begin
    if (m_started) begin
      chk("gnt_m0", bus.gnt_m0, (cyc == m_acc) && (m_own == 0));
      chk("gnt_m1", bus.gnt_m1, (cyc == m_acc) && (m_own == 1));
      chk("valid_reg_access", bus.valid_reg_access, cyc == m_acc);
      if (cyc == m_acc) begin
        chk("addr", bus.addr, m_addr);
        chk("rd_wr", bus.rd_wr, m_wr);
        if (m_wr) chk("write_data", bus.write_data, m_wdata);
      end
      chk("rvalid_m0", bus.rvalid_m0, (cyc == m_done) && (m_own == 0));
      chk("rvalid_m1", bus.rvalid_m1, (cyc == m_done) && (m_own == 1));
      chk("rdata_m0", bus.rdata_m0, m_rd[0]);
      chk("rdata_m1", bus.rdata_m1, m_rd[1]);
      if (pend0 && !HRESET) chk("req_held_m0", bus.req_m0, 1'b1);
      if (pend1 && !HRESET) chk("req_held_m1", bus.req_m1, 1'b1);
      pend0 = bus.req_m0 && !bus.gnt_m0;
      pend1 = bus.req_m1 && !bus.gnt_m1;
      if (bus.gnt_m0) begin gl_id.push_back(0); gl_cyc.push_back(cyc); end
      if (bus.gnt_m1) begin gl_id.push_back(1); gl_cyc.push_back(cyc); end
      if (bus.rvalid_m0) rv_cnt0++;
      if (bus.rvalid_m1) rv_cnt1++;
      if (bus.valid_reg_access) begin
        n_strobe++;
        st_addr = bus.addr;
        st_wd = bus.write_data;
        st_wr = bus.rd_wr;
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic gnt_of(input int id);
    return (id == 0) ? bus.gnt_m0 : bus.gnt_m1;
  endfunction

  function automatic logic rv_of(input int id);
    return (id == 0) ? bus.rvalid_m0 : bus.rvalid_m1;
  endfunction

  task automatic set_req(input int id, input logic v);
    if (id == 0) bus.req_m0 = v;
    else bus.req_m1 = v;
  endtask

  task automatic set_payload(input int id, input logic wr, input logic [15:0] a,
                             input logic [31:0] d);
    if (id == 0) begin
      bus.wr1_rd0_m0 = wr; bus.addr_m0 = a; bus.wdata_m0 = d;
    end else begin
      bus.wr1_rd0_m1 = wr; bus.addr_m1 = a; bus.wdata_m1 = d;
    end
  endtask

  task automatic wait_gnt(input int id, output int t);
    t = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      if (gnt_of(id)) begin
        t = cyc;
        break;
      end
    end
    chk("gnt_seen", t >= 0, 1'b1);
  endtask

  task automatic wait_rv(input int id, output int t);
    t = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      if (rv_of(id)) begin
        t = cyc;
        break;
      end
    end
    chk("rvalid_seen", t >= 0, 1'b1);
  endtask

  task automatic run_req(input int id, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [31:0] rd,
                         output int t_req, output int t_gnt, output int t_rv);
    set_payload(id, wr, a, d);
    bus.read_data = rd;
    set_req(id, 1'b1);
    t_req = cyc;
    wait_gnt(id, t_gnt);
    tick();
    set_req(id, 1'b0);
    wait_rv(id, t_rv);
  endtask

  int tr, tg, tv, tg2, rvc, base, ns, nrv0, g0, g1;

  initial begin
    bus.req_m0 = 0; bus.req_m1 = 0;
    set_payload(0, 1'b0, 16'h0, 32'h0);
    set_payload(1, 1'b0, 16'h0, 32'h0);
    bus.read_data = '0;
`ifdef CORE_TIMER_ARB_LOCK_EN
    bus.lock_m1 = 0;
`endif
    HRESET = 1;
    repeat (3) tick();
    HRESET = 0;
    @(negedge HCLK);
    chk("rst_valid", bus.valid_reg_access, 1'b0);
    chk("rst_addr", bus.addr, 16'h0);
    chk("rst_wdata", bus.write_data, 32'h0);
    chk("rst_rd_wr", bus.rd_wr, 1'b0);
    chk("rst_gnt", {bus.gnt_m0, bus.gnt_m1}, 2'b00);
    chk("rst_rvalid", {bus.rvalid_m0, bus.rvalid_m1}, 2'b00);
    tick();

    // Single m0 read.
    run_req(0, 1'b0, 16'h4000, 32'h0, 32'h1234_5678, tr, tg, tv);
    chk("t1_gnt_lat", tg - tr, 1);
    chk("t1_rv_lat", tv - tr, 3);
    chk("t1_rdata", bus.rdata_m0, 32'h1234_5678);
    tick();

    // m1 read, then m1 write must clear rdata_m1.
    run_req(1, 1'b0, 16'h4004, 32'h0, 32'hCAFE_0001, tr, tg, tv);
    chk("t2_rd_rdata", bus.rdata_m1, 32'hCAFE_0001);
    tick();
    ns = n_strobe;
    run_req(1, 1'b1, 16'h4008, 32'hDEAD_BEEF, 32'h5555_AAAA, tr, tg, tv);
    chk("t2_strobes", n_strobe - ns, 1);
    chk("t2_addr", st_addr, 16'h4008);
    chk("t2_wdata", st_wd, 32'hDEAD_BEEF);
    chk("t2_rd_wr", st_wr, 1'b1);
    chk("t2_wr_rdata", bus.rdata_m1, 32'h0);
    chk("t2_m0_hold", bus.rdata_m0, 32'h1234_5678);

    // Both requesting continuously after reset: alternate m0, m1, m0, m1.
    tick();
    HRESET = 1;
    tick();
    HRESET = 0;
    base = gl_id.size();
    set_payload(0, 1'b0, 16'h4000, 32'h0);
    set_payload(1, 1'b0, 16'h4004, 32'h0);
    bus.req_m0 = 1; bus.req_m1 = 1;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      if (bus.gnt_m0) g0++;
      if (bus.gnt_m1) g1++;
      tick();
      bus.read_data = 32'hC000_0000 + i;
      if (g0 >= 2) bus.req_m0 = 0;
      if (g1 >= 2) bus.req_m1 = 0;
    end
    chk("t3_ngnt", gl_id.size() - base, 4);
    for (int j = 0; j < 4; j++) begin
      if (base + j < gl_id.size()) begin
        chk("t3_order", gl_id[base+j], j % 2);
        if (j > 0) chk("t3_spacing", gl_cyc[base+j] - gl_cyc[base+j-1], 3);
      end
    end

    // Reset during RESP of an m0 read.
    tick();
    nrv0 = rv_cnt0;
    set_payload(0, 1'b0, 16'h400C, 32'h0);
    bus.read_data = 32'h7777_0000;
    bus.req_m0 = 1;
    wait_gnt(0, tg);
    tick();
    bus.req_m0 = 0;
    HRESET = 1;
    tick();
    HRESET = 0;
    @(negedge HCLK);
    chk("t4_valid", bus.valid_reg_access, 1'b0);
    chk("t4_gnt", {bus.gnt_m0, bus.gnt_m1}, 2'b00);
    chk("t4_rvalid", {bus.rvalid_m0, bus.rvalid_m1}, 2'b00);
    chk("t4_rdata_m0", bus.rdata_m0, 32'h0);
    chk("t4_addr", bus.addr, 16'h0);
    repeat (3) tick();
    chk("t4_no_rv0", rv_cnt0 - nrv0, 0);
    run_req(1, 1'b0, 16'h4010, 32'h0, 32'h0BAD_F00D, tr, tg, tv);
    chk("t4_m1_lat", tv - tr, 3);
    chk("t4_m1_rdata", bus.rdata_m1, 32'h0BAD_F00D);

    // Back-to-back m0 with req re-raised in the rvalid cycle.
    tick();
    set_payload(0, 1'b0, 16'h4000, 32'h0);
    bus.read_data = 32'h1111_1111;
    bus.req_m0 = 1;
    wait_gnt(0, tg);
    tick();
    bus.req_m0 = 0;
    tick();
    bus.req_m0 = 1;
    bus.read_data = 32'h2222_2222;
    @(negedge HCLK);
    chk("t5_rv", bus.rvalid_m0, 1'b1);
    chk("t5_rdata1", bus.rdata_m0, 32'h1111_1111);
    rvc = cyc;
    wait_gnt(0, tg2);
    chk("t5_regrant", tg2 - rvc, 1);
    tick();
    bus.req_m0 = 0;
    wait_rv(0, tv);
    chk("t5_rdata2", bus.rdata_m0, 32'h2222_2222);

`ifdef CORE_TIMER_ARB_LOCK_EN
    // Locked m1 pair holds off a waiting m0.
    tick();
    base = gl_id.size();
    set_payload(1, 1'b1, 16'h4010, 32'h1);
    bus.lock_m1 = 1;
    bus.req_m1 = 1;
    wait_gnt(1, tg);
    tick();
    set_payload(1, 1'b1, 16'h4014, 32'h2);
    bus.lock_m1 = 0;
    set_payload(0, 1'b0, 16'h4000, 32'h0);
    bus.req_m0 = 1;
    wait_gnt(1, tg);
    tick();
    bus.req_m1 = 0;
    wait_gnt(0, tg);
    tick();
    bus.req_m0 = 0;
    repeat (4) tick();
    chk("t6_ngnt", gl_id.size() - base, 3);
    for (int j = 0; j < 3; j++) begin
      if (base + j < gl_id.size()) begin
        chk("t6_order", gl_id[base+j], (j < 2) ? 1 : 0);
        if (j > 0) chk("t6_spacing", gl_cyc[base+j] - gl_cyc[base+j-1], 3);
      end
    end
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
